sevenseg_scan: RTL and testbench

- Time-multiplexes one shared combinational hex-to-segment decoder across NDIG common-anode digits.
- Outputs the active digit's 4-bit nibble to the decoder and drives the digit anodes (active-low).
- Double-buffers the display value so that updates take effect only at frame boundaries, which prevents tearing.
- Sits between the user logic that produces the value and the board's seven-segment pins.

---
 rtl/sevenseg_pkg.sv | 11 +
 rtl/scan_prescaler.sv | 21 ++
 rtl/sevenseg_scan.sv | 67 ++++++
 tb/tb_sevenseg_scan.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg: shared defaults, anode constant, nibble type and width helper for the scanner
package sevenseg_pkg;
    localparam int NDIG_DEF = 4;
    localparam logic [7:0] AN_OFF = 8'hFF;
    typedef logic [3:0] nibble_t;
    function automatic int width_of(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
    localparam int CNT_W_DEF = width_of(100000);
    localparam int DSEL_W_DEF = width_of(NDIG_DEF);
endpackage

// File: rtl/scan_prescaler.sv
// scan_prescaler: slot-cycle counter that wraps every TICK_DIV cycles and is held at 0 while disabled
module scan_prescaler
    import sevenseg_pkg::*;
#(
    parameter int TICK_DIV = 100000,
    parameter int CW = width_of(TICK_DIV)
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          tick
);
    logic last;
    assign last = cnt == CW'(TICK_DIV - 1);
    assign tick = en && last;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else cnt <= (!en || last) ? '0 : cnt + CW'(1);
    end
endmodule

// File: rtl/sevenseg_scan.sv
// sevenseg_scan: double-buffered multiplexed hex display scanner with active-low anodes
// Define SEVENSEG_LZB_EN to blank digits above the most significant non-zero nibble.
module sevenseg_scan
    import sevenseg_pkg::*;
#(
    parameter int NDIG = NDIG_DEF,
    parameter int TICK_DIV = 100000,
    parameter int BLANK_CYC = 64
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [4*NDIG-1:0] value_in,
    input  logic              load,
    output logic              upd_pending,
    output nibble_t           hex,
    output logic [NDIG-1:0]   an,
    output logic              frame_tick
);
    localparam int CW = width_of(TICK_DIV);
    localparam int DW = width_of(NDIG);
    logic [CW-1:0] cnt;
    logic [DW-1:0] dsel;
    logic [4*NDIG-1:0] disp, pend_val;
    logic tick, commit, take, dark;
    scan_prescaler #(.TICK_DIV(TICK_DIV), .CW(CW)) u_pre (
        .clk(clk), .rst_n(rst_n), .en(en), .cnt(cnt), .tick(tick)
    );
    assign commit = tick && dsel == DW'(NDIG - 1);
    // While disabled every cycle acts as a commit point so disp is current on resume.
    assign take = commit || !en;
`ifdef SEVENSEG_LZB_EN
    logic [DW-1:0] msd;
    always_comb begin
        msd = '0;
        for (int i = 1; i < NDIG; i++)
            if (disp[4*i +: 4] != 4'h0) msd = DW'(i);
    end
    assign dark = !en || int'(cnt) < BLANK_CYC || dsel > msd;
`else
    assign dark = !en || int'(cnt) < BLANK_CYC;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dsel <= '0;
            disp <= '0;
            pend_val <= '0;
            upd_pending <= 1'b0;
            hex <= '0;
            an <= AN_OFF[NDIG-1:0];
            frame_tick <= 1'b0;
        end else begin
            dsel <= !en ? '0 : tick ? (dsel == DW'(NDIG - 1) ? '0 : dsel + DW'(1)) : dsel;
            if (take) begin
                if (load) disp <= value_in;
                else if (upd_pending) disp <= pend_val;
                upd_pending <= 1'b0;
            end else if (load) begin
                pend_val <= value_in;
                upd_pending <= 1'b1;
            end
            hex <= disp[4*dsel +: 4];
            an <= dark ? AN_OFF[NDIG-1:0] : ~(NDIG'(1) << dsel);
            frame_tick <= commit;
        end
    end
endmodule

// File: tb/tb_sevenseg_scan.sv
// tb_sevenseg_scan: vector table, corner sequences and random traffic against a slot-arithmetic model
module tb_sevenseg_scan;
    localparam int NDIG = 4, TD = 8, BC = 2;
    logic clk = 1'b0, rst_n = 1'b0, en = 1'b1, load = 1'b0;
    logic [15:0] value_in = '0;
    logic upd_pending, frame_tick;
    logic [3:0] hex, an;
    int checks = 0, errors = 0;
    int t = 0;
    logic [15:0] m_disp = '0, m_pend = '0;
    bit m_has = 1'b0;

    always #5 clk = ~clk;

    sevenseg_scan #(.NDIG(NDIG), .TICK_DIV(TD), .BLANK_CYC(BC)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .value_in(value_in), .load(load),
        .upd_pending(upd_pending), .hex(hex), .an(an), .frame_tick(frame_tick)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, t);
        end
    endtask

`ifdef SEVENSEG_LZB_EN
    function automatic int top_digit(input logic [15:0] v);
        int m = 0;
        for (int i = 1; i < NDIG; i++) if (((v >> (4*i)) & 16'hF) != 0) m = i;
        return m;
    endfunction
`endif

    // Entered just after a negedge; drives one cycle, predicts and compares, returns after the next negedge.
    task automatic cyc(input bit e, input bit ld, input logic [15:0] v);
        int slot, c;
        bit commit, lit;
        logic [3:0] e_an, e_hex;
        en = e; load = ld; value_in = v;
        slot = (t / TD) % NDIG;
        c = t % TD;
        lit = e && c >= BC;
`ifdef SEVENSEG_LZB_EN
        lit = lit && slot <= top_digit(m_disp);
`endif
        e_an = lit ? 4'(~(1 << slot)) : 4'hF;
        e_hex = 4'((m_disp >> (4*slot)) & 16'hF);
        commit = e && c == TD - 1 && slot == NDIG - 1;
        if (!e || commit) begin
            if (ld) m_disp = v;
            else if (m_has) m_disp = m_pend;
            m_has = 1'b0;
        end else if (ld) begin
            m_pend = v;
            m_has = 1'b1;
        end
        t = e ? t + 1 : 0;
        @(posedge clk);
        #1;
        check("an", an, e_an);
        check("hex", hex, e_hex);
        check("frame_tick", frame_tick, commit);
        check("upd_pending", upd_pending, m_has);
        check("one_anode", 32'($countones(~an) <= 1), 1);
        @(negedge clk);
    endtask

    task automatic run_frame(output logic [15:0] got, output logic [3:0] mask,
                             output logic [3:0] first_lit, output bit saw_one);
        got = '0; mask = '0; first_lit = 4'hF; saw_one = 1'b0;
        for (int k = 0; k < NDIG*TD; k++) begin
            cyc(1'b1, 1'b0, 16'h0);
            if (an != 4'hF) begin
                mask |= ~an;
                if (first_lit == 4'hF) first_lit = an;
                if (hex == 4'h1) saw_one = 1'b1;
                for (int d = 0; d < NDIG; d++) if (an == 4'(~(1 << d))) got[4*d +: 4] = hex;
            end
        end
    endtask

    typedef struct {
        bit ld;
        logic [15:0] v;
        logic [3:0] an;
        logic [3:0] hex;
        bit ft;
        bit upd;
    } vec_t;
    vec_t tbl[$];

    initial begin
        logic [15:0] got;
        logic [3:0] mask, first_lit, lz_mask;
        bit saw_one;
        int guard;
        tbl.push_back('{1'b0, 16'h0, 4'hF, 4'h0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 16'h0, 4'hF, 4'h0, 1'b0, 1'b0});
        for (int k = 2; k < 8; k++) tbl.push_back('{1'b0, 16'h0, 4'hE, 4'h0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 16'h0, 4'hF, 4'h0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 16'h0, 4'hF, 4'h0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 16'h0, 4'hD, 4'h0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 16'h1234, 4'hD, 4'h0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 16'h0, 4'hD, 4'h0, 1'b0, 1'b1});

        repeat (3) @(posedge clk);
        #1;
        check("rst_an", an, 4'hF);
        check("rst_hex", hex, 4'h0);
        check("rst_upd", upd_pending, 1'b0);
        check("rst_ft", frame_tick, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            cyc(1'b1, tbl[i].ld, tbl[i].v);
            check("tbl_an", an, tbl[i].an);
            check("tbl_hex", hex, tbl[i].hex);
            check("tbl_ft", frame_tick, tbl[i].ft);
            check("tbl_upd", upd_pending, tbl[i].upd);
        end

        guard = 0;
        while (frame_tick !== 1'b1 && guard < 40) begin
            cyc(1'b1, 1'b0, 16'h0);
            guard++;
        end
        check("commit_seen", frame_tick, 1'b1);
        check("commit_upd", upd_pending, 1'b0);
        run_frame(got, mask, first_lit, saw_one);
        check("frame_1234", got, 16'h1234);
        check("frame_1234_first", first_lit, 4'hE);

        cyc(1'b1, 1'b1, 16'h1111);
        guard = 0;
        while (t % (NDIG*TD) != NDIG*TD - 1 && guard < 40) begin
            cyc(1'b1, 1'b0, 16'h0);
            guard++;
        end
        check("pend_1111", upd_pending, 1'b1);
        cyc(1'b1, 1'b1, 16'hABCD);
        check("race_ft", frame_tick, 1'b1);
        check("race_upd", upd_pending, 1'b0);
        run_frame(got, mask, first_lit, saw_one);
        check("frame_abcd", got, 16'hABCD);
        check("no_1111", saw_one, 1'b0);

        guard = 0;
        while (t % (NDIG*TD) != 2*TD + 3 && guard < 40) begin
            cyc(1'b1, 1'b0, 16'h0);
            guard++;
        end
        cyc(1'b0, 1'b0, 16'h0);
        check("endrop_an", an, 4'hF);
        cyc(1'b0, 1'b1, 16'h5678);
        cyc(1'b0, 1'b0, 16'h0);
        check("endrop_upd", upd_pending, 1'b0);
        run_frame(got, mask, first_lit, saw_one);
        check("resume_5678", got, 16'h5678);
        check("resume_digit0", first_lit, 4'hE);

        foreach (lz_mask[i]) lz_mask[i] = 1'b1;
`ifdef SEVENSEG_LZB_EN
        lz_mask = 4'b0011;
`endif
        cyc(1'b0, 1'b1, 16'h0040);
        run_frame(got, mask, first_lit, saw_one);
        check("lz_0040_mask", mask, lz_mask);
        check("lz_0040_val", got, 16'h0040);
`ifdef SEVENSEG_LZB_EN
        lz_mask = 4'b0001;
`endif
        cyc(1'b0, 1'b1, 16'h0000);
        run_frame(got, mask, first_lit, saw_one);
        check("lz_0000_mask", mask, lz_mask);

        for (int k = 0; k < 600; k++)
            cyc($urandom_range(0, 19) != 0, $urandom_range(0, 7) == 0, 16'($urandom));

        rst_n = 1'b0;
        #1;
        check("async_rst_an", an, 4'hF);
        check("async_rst_upd", upd_pending, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
